// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM state encoding, PC mux selects and the NOP instruction word.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_REDIR_WAIT,
      ST_DRAIN,
      ST_HALTED
   } ctrl_state_t;

   localparam logic [1:0] PCSEL_SEQ   = 2'b00;
   localparam logic [1:0] PCSEL_BR    = 2'b01;
   localparam logic [1:0] PCSEL_LATCH = 2'b10;

   localparam logic [15:0] NOP_INST = 16'h0800;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/status inputs and per-stage pipeline register controls
// exchanged between the stall sequencer and the datapath.
interface pipe_stall_ctrl_if;

   logic       hazard_n;
   logic       br_taken_ex;
   logic       halt_id;
   logic       imem_stall;
   logic       dmem_stall;

   logic       pc_we;
   logic [1:0] pc_sel;
   logic       tgt_latch_en;
   logic       ifid_we;
   logic       ifid_flush;
   logic       idex_we;
   logic       idex_bubble;
   logic       exmem_we;
   logic       memwb_we;
   logic       memwb_bubble;

   modport master (
      input  hazard_n, br_taken_ex, halt_id, imem_stall, dmem_stall,
      output pc_we, pc_sel, tgt_latch_en, ifid_we, ifid_flush,
             idex_we, idex_bubble, exmem_we, memwb_we, memwb_bubble
   );

   modport slave (
      output hazard_n, br_taken_ex, halt_id, imem_stall, dmem_stall,
      input  pc_we, pc_sel, tgt_latch_en, ifid_we, ifid_flush,
             idex_we, idex_bubble, exmem_we, memwb_we, memwb_bubble
   );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: per-cycle enables,
// bubbles and flushes, branch redirect under fetch stall, HALT drain, perf counters.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned DRAIN_CYC = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_stall_ctrl_if.master  ctl,
   output logic               halted,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

   ctrl_state_t   state, nxt_state;
   logic [DW-1:0] drain_cnt, nxt_drain;

   logic       pc_we, tgt_latch_en, ifid_we, ifid_flush;
   logic       idex_we, idex_bubble, exmem_we, memwb_we, memwb_bubble;
   logic [1:0] pc_sel;
   logic       stall_inc, flush_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
         halted    <= 1'b0;
      end else begin
         state     <= nxt_state;
         drain_cnt <= nxt_drain;
         halted    <= (nxt_state == ST_HALTED);
      end
   end

   always_comb begin
      nxt_state    = state;
      nxt_drain    = drain_cnt;
      flush_inc    = 1'b0;
      pc_we        = 1'b1;
      pc_sel       = PCSEL_SEQ;
      tgt_latch_en = 1'b0;
      ifid_we      = 1'b1;
      ifid_flush   = 1'b0;
      idex_we      = 1'b1;
      idex_bubble  = 1'b0;
      exmem_we     = 1'b1;
      memwb_we     = 1'b1;
      memwb_bubble = 1'b0;

      unique case (state)
         ST_RUN: begin
            if (ctl.dmem_stall) begin
               // EX is frozen, so a branch resolving there simply re-presents next cycle
               pc_we        = 1'b0;
               ifid_we      = 1'b0;
               idex_we      = 1'b0;
               exmem_we     = 1'b0;
               memwb_bubble = 1'b1;
            end else if (ctl.br_taken_ex) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               flush_inc   = 1'b1;
               if (ctl.imem_stall) begin
                  pc_we        = 1'b0;
                  tgt_latch_en = 1'b1;
                  nxt_state    = ST_REDIR_WAIT;
               end else begin
                  pc_sel = PCSEL_BR;
               end
            end else if (!ctl.hazard_n) begin
               pc_we       = 1'b0;
               ifid_we     = 1'b0;
               idex_bubble = 1'b1;
            end else if (ctl.halt_id) begin
               pc_we      = 1'b0;
               ifid_flush = 1'b1;
               nxt_drain  = DW'(DRAIN_CYC);
               nxt_state  = ST_DRAIN;
            end else if (ctl.imem_stall) begin
               pc_we      = 1'b0;
               ifid_flush = 1'b1;
            end
         end

         ST_REDIR_WAIT: begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            // A data-side freeze blocks the PC write, so the redirect waits it out
            if (ctl.dmem_stall) begin
               ifid_we      = 1'b0;
               idex_we      = 1'b0;
               exmem_we     = 1'b0;
               memwb_bubble = 1'b1;
            end else if (!ctl.imem_stall) begin
               pc_we     = 1'b1;
               pc_sel    = PCSEL_LATCH;
               nxt_state = ST_RUN;
            end
         end

         ST_DRAIN: begin
            pc_we       = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (ctl.dmem_stall) begin
               ifid_we      = 1'b0;
               idex_we      = 1'b0;
               exmem_we     = 1'b0;
               memwb_bubble = 1'b1;
            end else begin
               nxt_drain = drain_cnt - DW'(1);
               if (drain_cnt <= DW'(1))
                  nxt_state = ST_HALTED;
            end
         end

         ST_HALTED: begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
         end

         default: nxt_state = ST_RUN;
      endcase

      stall_inc = rst_n && !pc_we &&
                  ((state == ST_RUN) || (state == ST_REDIR_WAIT));

      if (!rst_n) begin
         flush_inc    = 1'b0;
         pc_we        = 1'b0;
         pc_sel       = PCSEL_SEQ;
         tgt_latch_en = 1'b0;
         ifid_we      = 1'b0;
         ifid_flush   = 1'b1;
         idex_we      = 1'b0;
         idex_bubble  = 1'b1;
         exmem_we     = 1'b0;
         memwb_we     = 1'b0;
         memwb_bubble = 1'b1;
      end
   end

   assign ctl.pc_we        = pc_we;
   assign ctl.pc_sel       = pc_sel;
   assign ctl.tgt_latch_en = tgt_latch_en;
   assign ctl.ifid_we      = ifid_we;
   assign ctl.ifid_flush   = ifid_flush;
   assign ctl.idex_we      = idex_we;
   assign ctl.idex_bubble  = idex_bubble;
   assign ctl.exmem_we     = exmem_we;
   assign ctl.memwb_we     = memwb_we;
   assign ctl.memwb_bubble = memwb_bubble;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .cnt   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .cnt   (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (CNT_W=4 build so saturation is reachable).
module tb_pipe_stall_ctrl;

   localparam int unsigned CNT_W = 4;

   // {pc_we, pc_sel[1:0], tgt_latch_en, ifid_we, ifid_flush,
   //  idex_we, idex_bubble, exmem_we, memwb_we, memwb_bubble}
   localparam logic [10:0] C_RST    = 11'b0_00_0_0_1_0_1_0_0_1;
   localparam logic [10:0] C_DEF    = 11'b1_00_0_1_0_1_0_1_1_0;
   localparam logic [10:0] C_HAZ    = 11'b0_00_0_0_0_1_1_1_1_0;
   localparam logic [10:0] C_BR     = 11'b1_01_0_1_1_1_1_1_1_0;
   localparam logic [10:0] C_BRLAT  = 11'b0_00_1_1_1_1_1_1_1_0;
   localparam logic [10:0] C_RWAIT  = 11'b0_00_0_1_1_1_0_1_1_0;
   localparam logic [10:0] C_RDONE  = 11'b1_10_0_1_1_1_0_1_1_0;
   localparam logic [10:0] C_FRZ    = 11'b0_00_0_0_0_0_0_0_1_1;
   localparam logic [10:0] C_HALT   = 11'b0_00_0_1_1_1_0_1_1_0;
   localparam logic [10:0] C_IMEM   = 11'b0_00_0_1_1_1_0_1_1_0;
   localparam logic [10:0] C_DRAIN  = 11'b0_00_0_1_1_1_1_1_1_0;
   localparam logic [10:0] C_DRFRZ  = 11'b0_00_0_0_1_0_1_0_1_1;
   localparam logic [10:0] C_HALTED = 11'b0_00_0_0_0_0_0_0_0_0;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [10:0]      ctl_vec;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   pipe_stall_ctrl_if pif ();

   pipe_stall_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctl       (pif),
      .halted    (halted),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   always #5 clk = ~clk;

   assign ctl_vec = {pif.pc_we, pif.pc_sel, pif.tgt_latch_en, pif.ifid_we, pif.ifid_flush,
                     pif.idex_we, pif.idex_bubble, pif.exmem_we, pif.memwb_we, pif.memwb_bubble};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Set inputs at the start of a cycle and move to the sampling point.
   task automatic apply(input logic br, input logic haz_n, input logic halt,
                        input logic imem, input logic dmem);
      pif.br_taken_ex = br;
      pif.hazard_n    = haz_n;
      pif.halt_id     = halt;
      pif.imem_stall  = imem;
      pif.dmem_stall  = dmem;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      apply(0, 1, 0, 0, 0);
      check("rst_ctl", 32'(ctl_vec), 32'(C_RST));
      check("rst_halted", 32'(halted), 0);
      check("rst_stall", 32'(stall_cnt), 0);
      tick();
      rst_n = 1'b1;

      apply(0, 1, 0, 0, 0); check("idle_ctl", 32'(ctl_vec), 32'(C_DEF)); tick();

      // RAW hazard for two cycles
      apply(0, 0, 0, 0, 0); check("haz0_ctl", 32'(ctl_vec), 32'(C_HAZ)); tick();
      apply(0, 0, 0, 0, 0); check("haz1_ctl", 32'(ctl_vec), 32'(C_HAZ)); tick();
      apply(0, 1, 0, 0, 0);
      check("haz_after_ctl", 32'(ctl_vec), 32'(C_DEF));
      check("haz_stall", 32'(stall_cnt), 2);
      tick();

      // Branch while fetch busy for 3 cycles
      apply(1, 1, 0, 1, 0); check("brlat_ctl", 32'(ctl_vec), 32'(C_BRLAT)); tick();
      apply(0, 1, 0, 1, 0); check("rwait1_ctl", 32'(ctl_vec), 32'(C_RWAIT));
      check("rwait_flush", 32'(flush_cnt), 1); tick();
      apply(0, 1, 0, 1, 0); check("rwait2_ctl", 32'(ctl_vec), 32'(C_RWAIT)); tick();
      apply(0, 1, 0, 0, 0); check("rdone_ctl", 32'(ctl_vec), 32'(C_RDONE)); tick();
      apply(0, 1, 0, 0, 0);
      check("redir_after_ctl", 32'(ctl_vec), 32'(C_DEF));
      check("redir_stall", 32'(stall_cnt), 5);
      tick();

      // Branch held under data-memory freeze
      apply(1, 1, 0, 0, 1); check("brfrz0_ctl", 32'(ctl_vec), 32'(C_FRZ)); tick();
      apply(1, 1, 0, 0, 1); check("brfrz1_ctl", 32'(ctl_vec), 32'(C_FRZ));
      check("brfrz_flush", 32'(flush_cnt), 1); tick();
      apply(1, 1, 0, 0, 0); check("brgo_ctl", 32'(ctl_vec), 32'(C_BR)); tick();
      apply(0, 1, 0, 0, 0);
      check("brgo_flush", 32'(flush_cnt), 2);
      check("brgo_stall", 32'(stall_cnt), 7);
      tick();

      // HALT drain with one freeze cycle; branch/hazard ignored while draining
      apply(0, 1, 1, 0, 0); check("halt_ctl", 32'(ctl_vec), 32'(C_HALT)); tick();
      apply(0, 1, 0, 0, 0); check("drain1_ctl", 32'(ctl_vec), 32'(C_DRAIN)); tick();
      apply(0, 1, 0, 0, 1); check("drfrz_ctl", 32'(ctl_vec), 32'(C_DRFRZ)); tick();
      apply(1, 0, 0, 0, 0); check("drain3_ctl", 32'(ctl_vec), 32'(C_DRAIN));
      check("drain3_halted", 32'(halted), 0); tick();
      apply(0, 1, 0, 0, 0); check("drain4_ctl", 32'(ctl_vec), 32'(C_DRAIN));
      check("drain4_halted", 32'(halted), 0); tick();
      apply(0, 1, 0, 0, 0); check("halted_ctl", 32'(ctl_vec), 32'(C_HALTED));
      check("halted_rise", 32'(halted), 1); tick();
      apply(1, 1, 0, 0, 0); check("halted_hold", 32'(halted), 1);
      check("halted_ctl2", 32'(ctl_vec), 32'(C_HALTED));
      check("halted_flush", 32'(flush_cnt), 2);
      check("halted_stall", 32'(stall_cnt), 8);
      tick();

      // Reset from HALTED, then reset again mid-DRAIN with counter at 2
      rst_n = 1'b0; #1;
      check("rst2_halted", 32'(halted), 0);
      tick();
      rst_n = 1'b1;
      apply(0, 1, 1, 0, 0); check("halt2_ctl", 32'(ctl_vec), 32'(C_HALT)); tick();
      apply(0, 1, 0, 0, 0); check("drain2_ctl", 32'(ctl_vec), 32'(C_DRAIN)); tick();
      rst_n = 1'b0; #1;
      check("midrst_ctl", 32'(ctl_vec), 32'(C_RST));
      check("midrst_stall", 32'(stall_cnt), 0);
      check("midrst_halted", 32'(halted), 0);
      tick();
      rst_n = 1'b1;
      apply(0, 1, 0, 0, 0); check("midrst_run_ctl", 32'(ctl_vec), 32'(C_DEF)); tick();

      // Fetch stall alone, then hazards until the counter saturates
      apply(0, 1, 0, 1, 0); check("imem_ctl", 32'(ctl_vec), 32'(C_IMEM)); tick();
      repeat (13) begin apply(0, 0, 0, 0, 0); tick(); end
      apply(0, 1, 0, 0, 0); check("sat_pre", 32'(stall_cnt), 14); tick();
      repeat (8) begin apply(0, 0, 0, 0, 0); tick(); end
      apply(0, 1, 0, 0, 0); check("sat_hold", 32'(stall_cnt), 15); tick();

      // Priority: branch beats hazard, branch beats HALT
      apply(1, 0, 0, 0, 0); check("br_haz_ctl", 32'(ctl_vec), 32'(C_BR)); tick();
      apply(1, 1, 1, 0, 0); check("br_halt_ctl", 32'(ctl_vec), 32'(C_BR)); tick();
      apply(0, 1, 0, 0, 0);
      check("br_halt_run", 32'(ctl_vec), 32'(C_DEF));
      check("prio_flush", 32'(flush_cnt), 2);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
